// File: rtl/sliced_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sliced_adder_pkg
// Description : Shared FSM state type and slice-count/index-width helpers
//               for the sliced adder.
// Revision    : 1.0 - initial release
// ============================================================================
package sliced_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // The index register needs at least one bit, even when only one slice exists
    function automatic int calc_idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int DEFAULT_NSLICE = calc_nslice(DEFAULT_WIDTH, DEFAULT_SLICE);
    localparam int DEFAULT_IDX_W  = calc_idx_w(DEFAULT_NSLICE);

endpackage
`default_nettype wire

// File: rtl/sliced_adder_slice.sv
`default_nettype none
// ============================================================================
// Module      : slice_adder
// Description : Combinational SLICE-bit ripple adder from full-adder cells;
//               exposes the carry into and out of its MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_adder #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cmsb_o,
    output logic             cout_o
);

    logic [SLICE:0] w_c;

    assign w_c[0] = cin_i;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
        assign w_c[i+1]  = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cmsb_o = w_c[SLICE-1];
    assign cout_o = w_c[SLICE];

endmodule
`default_nettype wire

// File: rtl/sliced_adder.sv
`default_nettype none
// ============================================================================
// Module      : sliced_adder
// Description : Multi-cycle adder processing SLICE bits per cycle, LSB first,
//               with valid/ready handshakes. SLICED_ADDER_SUB_EN enables op_i
//               subtraction (A + ~B + ~cin).
// Revision    : 1.0 - initial release
// ============================================================================
module sliced_adder
    import sliced_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDX_W  = calc_idx_w(NSLICE);

    if ((SLICE < 1) || (WIDTH < 4) || (WIDTH > 64) || ((WIDTH % SLICE) != 0)) begin : g_param_check
        $error("sliced_adder: WIDTH must be 4..64 and a multiple of SLICE");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_slice_sum;
    logic               w_slice_cmsb;
    logic               w_slice_cout;
    logic               w_last;

`ifdef SLICED_ADDER_SUB_EN
    // Subtraction is folded into the operands at capture time
    assign w_b_in   = op_i ? ~b_i   : b_i;
    assign w_cin_in = op_i ? ~cin_i : cin_i;
`else
    logic w_unused_op;
    assign w_unused_op = op_i;
    assign w_b_in      = b_i;
    assign w_cin_in    = cin_i;
`endif

    assign w_a_slice = a_q[idx_q*SLICE +: SLICE];
    assign w_b_slice = b_q[idx_q*SLICE +: SLICE];
    assign w_last    = (idx_q == IDX_W'(NSLICE - 1));

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (w_a_slice),
        .b_i    (w_b_slice),
        .cin_i  (carry_q),
        .sum_o  (w_slice_sum),
        .cmsb_o (w_slice_cmsb),
        .cout_o (w_slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = w_b_in;
                    carry_d = w_cin_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[idx_q*SLICE +: SLICE] = w_slice_sum;
                carry_d = w_slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                // Visible results change only once the final slice lands
                if (w_last) begin
                    sum_d   = acc_d;
                    cout_d  = w_slice_cout;
                    ovf_d   = w_slice_cmsb ^ w_slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: doc/sliced_adder.md
SLICED_ADDER -- requirements
Module: sliced_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; legal values 4..64.
REQ-002 Parameter SLICE, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of SLICE, with an elaboration error otherwise.
REQ-003 clk_i  in  1: single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1: synchronous, active-high reset.
REQ-005 a_i  in  WIDTH: operand A, sampled on input handshake.
REQ-006 b_i  in  WIDTH: operand B, sampled on input handshake.
REQ-007 cin_i  in  1: carry-in, sampled on input handshake.
REQ-008 op_i  in  1: 0 = add, 1 = subtract; sampled on input handshake.
REQ-009 in_valid_i  in  1: operands valid.
REQ-010 in_ready_o  out  1: block can accept operands.
REQ-011 sum_o  out  WIDTH: result.
REQ-012 cout_o  out  1: carry-out of the MSB.
REQ-013 ovf_o  out  1: two's-complement signed overflow.
REQ-014 out_valid_o  out  1: result valid.
REQ-015 out_ready_i  in  1: consumer accepts the result.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, with NSLICE = WIDTH/SLICE.
REQ-017 IDLE: in_ready_o=1 and out_valid_o=0; when in_valid_i=1, latch a_i, b_i, cin_i and op_i, clear the slice index to 0, and go to RUN.
REQ-018 RUN: each cycle, add slice k of A and B plus the carry register; write bits [k*SLICE +: SLICE] of the sum register; update the carry; increment k. Processing is LSB slice first.
REQ-019 After slice NSLICE-1 is processed, go to DONE; with input accepted at edge 0, out_valid_o SHALL assert after edge NSLICE.
REQ-020 DONE: out_valid_o=1, and sum_o, cout_o and ovf_o SHALL be held stable until out_ready_i=1; on that edge, go to IDLE.
REQ-021 in_ready_o SHALL be 0 in RUN and DONE; in_valid_i is ignored there. There is no input/output overlap, so throughput is one result per NSLICE+2 cycles minimum.
REQ-022 ovf_o SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-023 In RUN and IDLE, sum_o, cout_o and ovf_o SHALL show the previous result, or 0 after reset; they are only meaningful when out_valid_o=1.
REQ-024 With NSLICE=1, RUN SHALL last exactly one cycle.
REQ-025 Wrap-around: the result is modulo 2^WIDTH; excess is reported only via cout_o and ovf_o.

Reset
REQ-026 rst_i=1 SHALL force IDLE, clear the carry and index, and set sum_o=0, cout_o=0, ovf_o=0, out_valid_o=0 and in_ready_o=1 on the next edge.
REQ-027 Reset asserted in RUN or DONE SHALL discard the operation; no out_valid_o pulse follows.
REQ-028 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-029 Macro SLICED_ADDER_SUB_EN defined: when op_i=1, compute A + ~B + ~cin_i (that is, A - B - cin_i as borrow-in); cout_o is the raw carry, with 1 meaning no borrow.
REQ-030 Macro SLICED_ADDER_SUB_EN undefined: op_i SHALL stay a port but be ignored and treated as 0; no inversion logic is synthesised.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), NSLICE computation, and index width constant $clog2(NSLICE).
REQ-032 One sub-module, slice_adder, SHALL implement a combinational SLICE-bit ripple adder built from full-adder cells; it exposes the carry into and out of its MSB for ovf_o.

Verification (WIDTH=16, SLICE=4)
REQ-033 Add 0x00FF + 0x0001, cin 0 -> sum_o=0x0100, cout_o=0, ovf_o=0; out_valid_o rises 4 edges after input accept.
REQ-034 Add 0xFFFF + 0x0001 and 0x7FFF + 0x0001 -> 0x0000 with cout_o=1, ovf_o=0; then 0x8000 with cout_o=0, ovf_o=1.
REQ-035 Backpressure: out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0, and a new in_valid_i is not accepted.
REQ-036 rst_i for one cycle during RUN slice 2 -> next cycle IDLE, all outputs 0, and no out_valid_o for that operation.
REQ-037 With SLICED_ADDER_SUB_EN: 0x0005 - 0x0007, cin 0 -> sum_o=0xFFFE, cout_o=0. Without the macro: same stimulus with op_i=1 -> sum_o=0x000C.
REQ-038 Randomised back-to-back operations versus a reference model SHALL match in all cases.
